// File: rtl/fft_avalon_loader.sv
// ---------------------------------------------------------------------------
// fft_avalon_loader
//
// Avalon-MM slave that fills the FFT sample buffer one sample per write,
// reads samples back, fires fft_start once a full frame has been written
// and stalls the bus until the FFT core reports fft_done.
//
// Ports
//   clk, n_rst            clock, synchronous active-low reset
//   avs_write/avs_read    Avalon requests (write wins when both are high)
//   avs_address           sample index
//   avs_writedata         sample to store
//   avs_waitrequest       1 = request not accepted this cycle
//   avs_readdata          read result, qualified by avs_readdatavalid
//   buf_wen/waddr/wdata   sample RAM write port
//   buf_raddr/buf_rdata   sample RAM read port (one-cycle read latency)
//   fft_start             one-cycle pulse, frame complete
//   fft_done              one-cycle pulse from the FFT core
//   busy                  high from fft_start until fft_done
//   err                   sticky out-of-range flag, cleared by fft_start
//   sample_cnt            accepted in-range writes in the current frame
//
// Handshake: the master holds its request, address and write data until it
// samples avs_waitrequest low at a rising edge; that edge completes the
// transaction. avs_readdatavalid is high for exactly one cycle (RD_ACK) and
// qualifies avs_readdata in that same cycle. Address and write data are
// captured when the request leaves IDLE, so a master that drops its request
// early still sees the transaction complete without an extra response.
// ---------------------------------------------------------------------------
module fft_avalon_loader #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int N_SAMPLES   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             avs_write,
    input  logic                             avs_read,
    input  logic [ADDR_W-1:0]                avs_address,
    input  logic [DATA_W-1:0]                avs_writedata,
    output logic                             avs_waitrequest,
    output logic [DATA_W-1:0]                avs_readdata,
    output logic                             avs_readdatavalid,
    output logic                             buf_wen,
    output logic [ADDR_W-1:0]                buf_waddr,
    output logic [DATA_W-1:0]                buf_wdata,
    output logic [ADDR_W-1:0]                buf_raddr,
    input  logic [DATA_W-1:0]                buf_rdata,
    output logic                             fft_start,
    input  logic                             fft_done,
    output logic                             busy,
    output logic                             err,
    output logic [$clog2(N_SAMPLES+1)-1:0]   sample_cnt
);

    localparam int CNT_W = $clog2(N_SAMPLES+1);

    localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W+1)'(N_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N_SAMPLES-1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       WAIT_LAST  = 4'(WAIT_CYCLES-1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_ACK  = 3'd2,
        RD_ADDR = 3'd3,
        RD_ACK  = 3'd4,
        START   = 3'd5,
        BUSY    = 3'd6
    } state_t;

    // state is kept as a named signal so checkers can bind to it directly
    state_t              state;
    logic [3:0]          wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                in_range;

    assign in_range = ({1'b0, addr_q} < ADDR_LIMIT);

    // -----------------------------------------------------------------------
    // Control FSM. The IDLE cycle in which a write is first seen is wait
    // cycle 0, so a write holds waitrequest high for WAIT_CYCLES cycles and
    // takes WAIT_CYCLES+1 cycles in total. With WAIT_CYCLES == 1 the
    // WR_WAIT state is skipped entirely.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            addr_q     <= '0;
            data_q     <= '0;
            sample_cnt <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (avs_write) begin
                        addr_q <= avs_address;
                        data_q <= avs_writedata;
                        if (WAIT_CYCLES <= 1) begin
                            state <= WR_ACK;
                        end else begin
                            wait_cnt <= 4'd1;
                            state    <= WR_WAIT;
                        end
                    end else if (avs_read) begin
                        addr_q <= avs_address;
                        state  <= RD_ADDR;
                    end
                end
                WR_WAIT: begin
                    if (wait_cnt >= WAIT_LAST) begin
                        state <= WR_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WR_ACK: begin
                    if (in_range) begin
                        sample_cnt <= sample_cnt + CNT_ONE;
                        // frame is defined by write count, not address coverage
                        state <= (sample_cnt == CNT_LAST) ? START : IDLE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                RD_ADDR: begin
                    state <= RD_ACK;
                end
                RD_ACK: begin
                    if (!in_range) begin
                        err <= 1'b1;
                    end
                    state <= IDLE;
                end
                START: begin
                    sample_cnt <= '0;
                    err        <= 1'b0;
                    state      <= BUSY;
                end
                BUSY: begin
                    if (fft_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs are decoded from the state register and the captured request.
    // Read data passes straight from the RAM in RD_ACK because the RAM
    // answers one cycle after buf_raddr is presented in RD_ADDR.
    // -----------------------------------------------------------------------
    always_comb begin
        avs_waitrequest   = 1'b1;
        avs_readdata      = '0;
        avs_readdatavalid = 1'b0;
        buf_wen           = 1'b0;
        buf_waddr         = '0;
        buf_wdata         = '0;
        buf_raddr         = '0;
        fft_start         = 1'b0;
        busy              = 1'b0;
        case (state)
            WR_ACK: begin
                avs_waitrequest = 1'b0;
                if (in_range) begin
                    buf_wen   = 1'b1;
                    buf_waddr = addr_q;
                    buf_wdata = data_q;
                end
            end
            RD_ADDR: begin
                buf_raddr = addr_q;
            end
            RD_ACK: begin
                avs_waitrequest   = 1'b0;
                avs_readdatavalid = 1'b1;
                if (in_range) begin
                    avs_readdata = buf_rdata;
                end
            end
            START: begin
                fft_start = 1'b1;
            end
            BUSY: begin
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
